// File: rtl/lsu_dmem_master.sv
// -----------------------------------------------------------------------------
// lsu_dmem_master
//
// Purpose:
//   Load/store unit that takes one load or store request per handshake and
//   drives it onto a data_memory port. Naturally aligned accesses go out as a
//   single memory beat, and the memory does the load extension. Misaligned
//   halfword and word accesses are split into byte beats. For loads, the bytes
//   are reassembled little-endian and then sign- or zero-extended here.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we                1 = store, 0 = load
//   req_funct3            size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr, req_wdata   byte address, right-justified store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    extended load data (0 for stores), illegal flag
//   address, datawr,      registered memory port towards data_memory
//   dmwr, dmctrl
//   datard                combinational read data from data_memory
// -----------------------------------------------------------------------------
module lsu_dmem_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] address,
    output logic [31:0] datawr,
    output logic        dmwr,
    output logic [2:0]  dmctrl,
    input  logic [31:0] datard
);

    typedef enum logic [1:0] {IDLE, ACCESS, SPLIT, RESP} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_beat;
    logic [31:0] r_asm;

    logic [31:0] r_address;
    logic [31:0] r_datawr;
    logic        r_dmwr;
    logic [2:0]  r_dmctrl;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;

    logic        w_illegal;
    logic        w_aligned;
    logic        w_last_beat;
    logic [1:0]  w_beat_next;
    logic [7:0]  w_split_wbyte;
    logic [31:0] w_asm_next;
    logic [31:0] w_asm_ext;

    // Legality of the incoming request: unsigned sizes exist only for loads.
    always_comb begin
        w_illegal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: w_illegal = 1'b0;
            F3_BU, F3_HU:     w_illegal = req_we;
            default:          w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_aligned = 1'b1;
        case (req_funct3)
            F3_H, F3_HU: w_aligned = ~req_addr[0];
            F3_W:        w_aligned = (req_addr[1:0] == 2'b00);
            default:     w_aligned = 1'b1;
        endcase
    end

    // Split transfers only exist for H/HU (2 beats) and W (4 beats).
    assign w_last_beat   = (r_beat == ((r_funct3 == F3_W) ? 2'd3 : 2'd1));
    assign w_beat_next   = r_beat + 2'd1;
    assign w_split_wbyte = r_wdata[{w_beat_next, 3'b000} +: 8];

    // Assembly register with the byte of the current beat merged in, so the
    // final beat's byte is included in the response without an extra cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_asm
            assign w_asm_next[8*gi +: 8] = (r_beat == 2'(gi)) ? datard[7:0]
                                                               : r_asm[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        w_asm_ext = w_asm_next;
        case (r_funct3)
            F3_H:    w_asm_ext = {{16{w_asm_next[15]}}, w_asm_next[15:0]};
            F3_HU:   w_asm_ext = {16'b0, w_asm_next[15:0]};
            default: w_asm_ext = w_asm_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= 3'b000;
            r_addr      <= 32'b0;
            r_wdata     <= 32'b0;
            r_beat      <= 2'b0;
            r_asm       <= 32'b0;
            r_address   <= 32'b0;
            r_datawr    <= 32'b0;
            r_dmwr      <= 1'b0;
            r_dmctrl    <= F3_W;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            // Outputs default to their idle values; states override them below.
            r_address   <= 32'b0;
            r_datawr    <= 32'b0;
            r_dmwr      <= 1'b0;
            r_dmctrl    <= F3_W;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'b0;
            r_rsp_err   <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_beat   <= 2'b0;
                        r_asm    <= 32'b0;
                        if (w_illegal) begin
                            r_state     <= RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (w_aligned) begin
                            // Beat outputs are loaded on the accept edge so the
                            // beat is visible in the first ACCESS cycle.
                            r_state   <= ACCESS;
                            r_address <= req_addr;
                            r_datawr  <= req_wdata;
                            r_dmwr    <= req_we;
                            r_dmctrl  <= req_funct3;
                        end else begin
                            r_state   <= SPLIT;
                            r_address <= req_addr;
                            r_datawr  <= req_we ? {24'b0, req_wdata[7:0]} : 32'b0;
                            r_dmwr    <= req_we;
                            r_dmctrl  <= req_we ? F3_B : F3_BU;
                        end
                    end
                end

                ACCESS: begin
                    r_state     <= RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= r_we ? 32'b0 : datard;
                end

                SPLIT: begin
                    if (!r_we) begin
                        r_asm <= w_asm_next;
                    end
                    if (w_last_beat) begin
                        r_state     <= RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= r_we ? 32'b0 : w_asm_ext;
                    end else begin
                        r_beat    <= w_beat_next;
                        r_address <= r_addr + {30'b0, w_beat_next};
                        r_datawr  <= r_we ? {24'b0, w_split_wbyte} : 32'b0;
                        r_dmwr    <= r_we;
                        r_dmctrl  <= r_we ? F3_B : F3_BU;
                    end
                end

                RESP: begin
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign address   = r_address;
    assign datawr    = r_datawr;
    assign dmwr      = r_dmwr;
    assign dmctrl    = r_dmctrl;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_dmem_master
//
// Bench for lsu_dmem_master. It provides a 256-byte data_memory model on the
// memory port, and a transaction-level reference that expands each request into
// the expected per-cycle port activity and response. That activity is checked on
// every falling edge. Directed scenarios pin the reference to hand-computed
// values. A randomized phase follows, then a reset in the middle of a split
// transfer.
// -----------------------------------------------------------------------------
module tb_lsu_dmem_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] address;
    logic [31:0] datawr;
    logic        dmwr;
    logic [2:0]  dmctrl;
    logic [31:0] datard;

    lsu_dmem_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .address    (address),
        .datawr     (datawr),
        .dmwr       (dmwr),
        .dmctrl     (dmctrl),
        .datard     (datard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- data_memory model (addresses wrap at 256 bytes) -------
    logic [7:0] dmem    [256];
    logic [7:0] ref_mem [256];

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [2:0] c);
        logic [7:0]  i;
        logic [31:0] w;
        i = a[7:0];
        w = {dmem[i + 8'd3], dmem[i + 8'd2], dmem[i + 8'd1], dmem[i]};
        case (c)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'b0, w[7:0]};
            3'b101:  return {16'b0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb datard = mem_read(address, dmctrl);

    task automatic mem_loop();
        logic [7:0] i;
        forever begin
            @(posedge clk);
            if (dmwr) begin
                i = address[7:0];
                dmem[i] = datawr[7:0];
                if (dmctrl == 3'b001 || dmctrl == 3'b010) dmem[i + 8'd1] = datawr[15:8];
                if (dmctrl == 3'b010) begin
                    dmem[i + 8'd2] = datawr[23:16];
                    dmem[i + 8'd3] = datawr[31:24];
                end
            end
        end
    endtask

    // ---------------- reference model ----------------------------------------
    typedef struct packed {
        logic [31:0] e_addr;
        logic [31:0] e_wr;
        logic        e_we;
        logic [2:0]  e_ctl;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_err;
        logic        e_rdy;
    } exp_t;

    exp_t        exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic        chk_en   = 1'b0;
    logic [31:0] last_rdata;
    logic        last_err;

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] d, input logic w,
                                input logic [2:0] c, input logic rv, input logic [31:0] rd,
                                input logic er, input logic rdy);
        exp_t e;
        e.e_addr = a; e.e_wr = d; e.e_we = w; e.e_ctl = c;
        e.e_rv = rv; e.e_rd = rd; e.e_err = er; e.e_rdy = rdy;
        return e;
    endfunction

    // Expected port activity for one request, starting in the cycle after accept.
    task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        int          size;
        logic [31:0] ak;
        logic [31:0] val;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2])) begin
            exp_q.push_back(mk(32'd0, 32'd0, 1'b0, 3'b010, 1'b1, 32'd0, 1'b1, 1'b0));
            return;
        end
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        val  = 32'd0;
        for (int k = 0; k < size; k++) begin
            ak = a + 32'(k);
            if (we) ref_mem[ak[7:0]] = wd[8*k +: 8];
            else    val[8*k +: 8]   = ref_mem[ak[7:0]];
        end
        if (!we && !f3[2] && size < 4 && val[8*size-1])
            val = val | ~((32'd1 << (8*size)) - 32'd1);
        if ((a & 32'(size - 1)) == 32'd0) begin
            exp_q.push_back(mk(a, wd, we, f3, 1'b0, 32'd0, 1'b0, 1'b0));
        end else begin
            for (int k = 0; k < size; k++)
                exp_q.push_back(mk(a + 32'(k), we ? {24'b0, wd[8*k +: 8]} : 32'd0, we,
                                   we ? 3'b000 : 3'b100, 1'b0, 32'd0, 1'b0, 1'b0));
        end
        exp_q.push_back(mk(32'd0, 32'd0, 1'b0, 3'b010, 1'b1, we ? 32'd0 : val, 1'b0, 1'b0));
    endtask

    // Per-cycle comparison: with nothing outstanding the DUT must sit idle.
    task automatic compare_loop();
        exp_t e;
        exp_t a;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (exp_q.size() > 0) e = exp_q.pop_front();
                else e = mk(32'd0, 32'd0, 1'b0, 3'b010, 1'b0, 32'd0, 1'b0, 1'b1);
                a = mk(address, datawr, dmwr, dmctrl, rsp_valid, rsp_rdata, rsp_err, req_ready);
                if (!e.e_rv) begin
                    a.e_rd = 32'd0; a.e_err = 1'b0; e.e_rd = 32'd0; e.e_err = 1'b0;
                end
                n_assert++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL port_cycle t=%0t got addr=%08h wr=%08h we=%b ctl=%03b rv=%b rd=%08h err=%b rdy=%b want addr=%08h wr=%08h we=%b ctl=%03b rv=%b rd=%08h err=%b rdy=%b",
                             $time, a.e_addr, a.e_wr, a.e_we, a.e_ctl, a.e_rv, a.e_rd, a.e_err, a.e_rdy,
                             e.e_addr, e.e_wr, e.e_we, e.e_ctl, e.e_rv, e.e_rd, e.e_err, e.e_rdy);
                end
                if (rsp_valid) begin
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
            end
        end
    endtask

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] want);
        n_assert++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s got=%08h want=%08h", name, act, want);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int t;
        @(negedge clk); #1;
        t = 0;
        while (!req_ready && t < 20) begin @(negedge clk); #1; t++; end
        check_lit("req_ready_wait", {31'b0, req_ready}, 32'd1);
        last_rdata = 32'hDEADBEEF;
        last_err   = 1'b0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        model_req(we, f3, a, wd);
        @(posedge clk); #1;
        // Junk request held for one busy cycle; it must be ignored.
        req_we = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t = 0;
        while (exp_q.size() > 0 && t < 20) begin @(negedge clk); #2; t++; end
        check_lit("rsp_timeout", exp_q.size(), 32'd0);
        rd = last_rdata;
        er = last_err;
        $display("req we=%0d f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0d",
                 we, f3, a, wd, rd, er);
    endtask

    // ---------------- stimulus ------------------------------------------------
    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] ra;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'd0; req_wdata = 32'd0;
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            dmem[i]    = 8'($urandom);
            ref_mem[i] = dmem[i];
        end
        fork
            mem_loop();
            compare_loop();
            begin
                #2000000;
                $display("FAIL watchdog expired");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        check_lit("rst_ready",  {31'b0, req_ready}, 32'd1);
        check_lit("rst_rvalid", {31'b0, rsp_valid}, 32'd0);
        check_lit("rst_rdata",  rsp_rdata, 32'd0);
        check_lit("rst_dmctrl", {29'b0, dmctrl}, 32'd2);
        check_lit("rst_dmwr",   {31'b0, dmwr}, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Aligned halfword with both extensions.
        do_req(1'b1, 3'b001, 32'd10, 32'h0000AAAA, rd, er);
        do_req(1'b0, 3'b001, 32'd10, 32'd0, rd, er);
        check_lit("lh_10", rd, 32'hFFFFAAAA);
        do_req(1'b0, 3'b101, 32'd10, 32'd0, rd, er);
        check_lit("lhu_10", rd, 32'h0000AAAA);

        // Misaligned word.
        do_req(1'b1, 3'b010, 32'h13, 32'h11223344, rd, er);
        do_req(1'b0, 3'b010, 32'h13, 32'd0, rd, er);
        check_lit("lw_13", rd, 32'h11223344);
        do_req(1'b0, 3'b010, 32'h14, 32'd0, rd, er);

        // Misaligned signed halfword.
        do_req(1'b1, 3'b000, 32'h21, 32'h80, rd, er);
        do_req(1'b1, 3'b000, 32'h22, 32'h7F, rd, er);
        do_req(1'b0, 3'b001, 32'h21, 32'd0, rd, er);
        check_lit("lh_21_pos", rd, 32'h00007F80);
        do_req(1'b1, 3'b000, 32'h22, 32'h80, rd, er);
        do_req(1'b0, 3'b001, 32'h21, 32'd0, rd, er);
        check_lit("lh_21_neg", rd, 32'hFFFF8080);
        do_req(1'b0, 3'b101, 32'h21, 32'd0, rd, er);
        check_lit("lhu_21", rd, 32'h00008080);

        // Illegal requests.
        do_req(1'b0, 3'b011, 32'h40, 32'd0, rd, er);
        check_lit("ill_ld_err", {31'b0, er}, 32'd1);
        check_lit("ill_ld_rd", rd, 32'd0);
        do_req(1'b1, 3'b100, 32'h40, 32'h12345678, rd, er);
        check_lit("ill_st_err", {31'b0, er}, 32'd1);

        // Address wrap.
        do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000BEEF, rd, er);
        check_lit("wrap_b0", {24'b0, dmem[255]}, 32'hEF);
        check_lit("wrap_b1", {24'b0, dmem[0]}, 32'hBE);
        do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'd0, rd, er);
        check_lit("lh_wrap", rd, 32'hFFFFBEEF);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                             : 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, rd, er);
        end

        // Reset in the middle of a split store.
        do_req(1'b1, 3'b000, 32'h13, 32'h00, rd, er);
        do_req(1'b1, 3'b000, 32'h14, 32'h00, rd, er);
        do_req(1'b1, 3'b000, 32'h15, 32'hA5, rd, er);
        do_req(1'b1, 3'b000, 32'h16, 32'h5A, rd, er);
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h13; req_wdata = 32'h11223344;
        exp_q.push_back(mk(32'h13, 32'h44, 1'b1, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0));
        exp_q.push_back(mk(32'h14, 32'h33, 1'b1, 3'b000, 1'b0, 32'd0, 1'b0, 1'b0));
        ref_mem[8'h13] = 8'h44;
        ref_mem[8'h14] = 8'h33;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_lit("mid_rst_addr",  address, 32'd0);
        check_lit("mid_rst_wr",    datawr, 32'd0);
        check_lit("mid_rst_dmwr",  {31'b0, dmwr}, 32'd0);
        check_lit("mid_rst_ctl",   {29'b0, dmctrl}, 32'd2);
        check_lit("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check_lit("mid_rst_rvalid", {31'b0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        check_lit("mid_rst_q", exp_q.size(), 32'd0);
        exp_q.delete();
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); #1;
        check_lit("post_rst_ready", {31'b0, req_ready}, 32'd1);
        check_lit("mem_13", {24'b0, dmem[8'h13]}, 32'h44);
        check_lit("mem_14", {24'b0, dmem[8'h14]}, 32'h33);
        check_lit("mem_15", {24'b0, dmem[8'h15]}, 32'hA5);
        check_lit("mem_16", {24'b0, dmem[8'h16]}, 32'h5A);
        do_req(1'b0, 3'b010, 32'h13, 32'd0, rd, er);
        check_lit("lw_after_rst", rd, 32'h5AA53344);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
# lsu_dmem_master

Load/store unit that sits between the execute stage and `data_memory`, acting as the initiator on the memory's `address`/`datawr`/`dmwr`/`dmctrl`/`datard` port. It accepts one load or store request per handshake and sequences it onto the memory port. Naturally aligned accesses complete in one memory beat. Misaligned halfword and word accesses are split into byte beats, then reassembled and extended.

## Interface
- No parameters; data and address widths are fixed at 32.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept; equals `state==IDLE`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V size code:
  - 000 = B, 001 = H, 010 = W, 100 = BU, 101 = HU.
  - Codes 100 and 101 are loads only.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: one-cycle completion pulse for loads and stores.
- `rsp_rdata` out 32: extended load result; 0 for stores.
- `rsp_err` out 1: illegal request, qualified by `rsp_valid`.
- `address` out 32: to `data_memory`.
- `datawr` out 32: to `data_memory`.
- `dmwr` out 1: memory write enable.
- `dmctrl` out 3: memory size code.
- `datard` in 32: combinational read data from `data_memory`, valid in the same cycle as `address`.

## Operation
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - Memory outputs are `address=0`, `datawr=0`, `dmwr=0`, `dmctrl=3'b010`.
  - On `req_valid & req_ready`, register we/funct3/addr/wdata.
  - Next state: RESP with err=1 if illegal, else ACCESS if aligned, else SPLIT.
- Illegal requests:
  - funct3 ∈ {011, 110, 111}.
  - Store with funct3 ∈ {100, 101}.
  - No memory beat is issued and `dmwr` never rises.
- Alignment rules:
  - Byte accesses are always aligned.
  - H/HU are aligned iff `addr[0]==0`.
  - W is aligned iff `addr[1:0]==0`.
- ACCESS (one beat):
  - Drive `address=addr`, `dmctrl=funct3`, `dmwr=we`, `datawr=wdata`.
  - Loads capture `datard` unchanged; the memory performs the extension.
  - Next state: RESP.
- SPLIT:
  - Beat count N = 2 for H/HU and 4 for W.
  - Beat k (k = 0..N-1) drives `address = addr + k`, modulo 2^32 (wraps).
  - Store beat: `dmctrl=000`, `dmwr=1`, `datawr = {24'b0, wdata[8k+7:8k]}`.
  - Load beat: `dmctrl=100`, `dmwr=0`, `datawr=0`; `datard[7:0]` is captured into byte k of the assembly register (little-endian).
  - After beat N-1, go to RESP.
  - Load extension on assembled data: H sign-extends from bit 15, HU zero-extends from bit 16 up, W is unmodified.
- RESP:
  - `rsp_valid=1` for exactly one cycle with `rsp_rdata` and `rsp_err`.
  - Memory outputs are at idle values.
  - Next state: IDLE.
- No response backpressure; the consumer must take the pulse.

## Timing
- Reset values:
  - state=IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`.
  - `address=0`, `datawr=0`, `dmwr=0`, `dmctrl=3'b010`.
  - Beat counter and assembly register 0.
- All memory-port outputs are registered. `req_ready` is decoded from state.
- Latency from the accept edge (cycle 0):
  - Aligned: beat in cycle 1, `rsp_valid` in cycle 2.
  - Misaligned H: beats in cycles 1–2, `rsp_valid` in cycle 3.
  - Misaligned W: beats in cycles 1–4, `rsp_valid` in cycle 5.
  - Illegal: `rsp_valid` in cycle 1.
- Earliest next accept is the cycle after `rsp_valid`; `req_ready` is low from ACCESS through RESP.
- `req_*` inputs are ignored while `req_ready=0`.
- Reset asserted mid-SPLIT:
  - All outputs go to reset values immediately.
  - No further beats are issued and no `rsp_valid` is produced.
  - Bytes already written remain in memory.

## Test plan
- **Halfword store/load with both extensions:** SH addr=10, wdata=0x0000AAAA.
  - Expect one beat: `address=10`, `dmctrl=001`, `dmwr=1`.
  - Then LH addr=10 → `rsp_rdata=0xFFFFAAAA`; LHU addr=10 → `0x0000AAAA`.
  - `rsp_valid` two cycles after each accept.
- **Misaligned word store then load:** SW addr=0x13, wdata=0x11223344.
  - Expect four byte beats at 0x13/0x14/0x15/0x16 with `datawr` 0x44/0x33/0x22/0x11, `dmctrl=000`, `rsp_valid` in cycle 5.
  - Then LW 0x13 → `0x11223344` in cycle 5.
  - Then LW 0x14 (aligned) → upper byte equals the prior memory contents.
- **Misaligned signed halfword:** memory bytes 0x21=0x80, 0x22=0x7F; LH 0x21 → `0x00007F80`.
  - With 0x22=0x80 instead: LH → `0xFFFF80xx`, where xx is byte 0x21. LHU → `0x000080xx`.
- **Illegal requests:**
  - funct3=011 load → `rsp_valid` in cycle 1 with `rsp_err=1`, `rsp_rdata=0`, no beat.
  - Store with funct3=100 → `rsp_err=1`, `dmwr` stays 0.
- **Address wrap:** SH addr=0xFFFFFFFF, wdata=0xBEEF → beats at 0xFFFFFFFF (0xEF) then 0x00000000 (0xBE); LH back → `0xFFFFBEEF`.
- **Reset mid-split:** SW 0x13, deassert `rst_n` after beat 1.
  - Outputs return to reset values immediately, no `rsp_valid`.
  - Bytes 0x13 and 0x14 are written; 0x15 and 0x16 are unchanged.
  - `req_ready=1` after release.
